// File: rtl/debug_trap_ctrl_pkg.sv
// Shared definitions for the #DB trap controller: FSM encoding and DR6/DR7 bit positions.
// Optional GD (general-detect) support is enabled by defining AO486_DEBUG_GD_EN.
package debug_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_TRAP_REQ  = 2'd1,
    ST_FAULT_REQ = 2'd2
  } dbg_state_t;

  // DR7 fields: L_i/G_i pairs start at bit 0, general-detect at bit 13
  localparam int DR7_LG_BASE = 0;
  localparam int DR7_GD      = 13;

  // DR6 fields
  localparam int DR6_B0 = 0;
  localparam int DR6_BD = 13;
  localparam int DR6_BS = 14;

endpackage

// File: rtl/debug_trap_ctrl_enable_decode.sv
// Combinational DR7 L/G decode: a breakpoint is enabled when either its local or global bit is set.
module debug_bp_enable_decode
  import debug_trap_ctrl_pkg::*;
#(
  parameter int NUM_BP = 4
) (
  input  logic [2*NUM_BP-1:0] dr7_lg,
  output logic [NUM_BP-1:0]   en
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : g_en
      assign en[gi] = dr7_lg[DR7_LG_BASE + 2*gi] | dr7_lg[DR7_LG_BASE + 2*gi + 1];
    end
  endgenerate

endmodule

// File: rtl/debug_trap_ctrl.sv
// Debug exception (#DB) sequencer: accumulates breakpoint hits, qualifies them against DR7 and
// single-step, and issues the #DB request plus DR6 update. AO486_DEBUG_GD_EN adds GD faults and gd_clr.
module debug_trap_ctrl
  import debug_trap_ctrl_pkg::*;
#(
  parameter int NUM_BP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dr7,
  input  logic [NUM_BP-1:0] rd_debug_read,
  input  logic              rd_ready,
  input  logic [NUM_BP-1:0] wr_debug_write,
  input  logic              wr_valid,
  input  logic [NUM_BP-1:0] exe_debug_exec,
  input  logic              exe_start,
  input  logic              eflags_rf,
  input  logic              eflags_tf,
  input  logic              instr_done,
  input  logic              flush,
  input  logic              exc_ack,
  input  logic              mov_dr_access,
  output logic              debug_exc_req,
  output logic              debug_exc_fault,
  output logic              dr6_wr,
  output logic [NUM_BP-1:0] dr6_b,
  output logic              dr6_bs,
  output logic              dr6_bd,
`ifdef AO486_DEBUG_GD_EN
  output logic              gd_clr,
`endif
  output logic              busy
);

  dbg_state_t        state_reg, state_next;
  logic [NUM_BP-1:0] pend_reg, pend_next;
  logic              tf_l_reg, tf_l_next;
  logic              dr6_wr_reg, dr6_wr_next;
  logic [NUM_BP-1:0] dr6_b_reg, dr6_b_next;
  logic              dr6_bs_reg, dr6_bs_next;
  logic              dr6_bd_reg, dr6_bd_next;

  logic [NUM_BP-1:0] en;
  logic [NUM_BP-1:0] new_hits;
  logic [NUM_BP-1:0] acc_hits;
  logic [NUM_BP-1:0] code_hits;
  logic              trap_go;
  logic              fault_go;
  logic              gd_go;

  debug_bp_enable_decode #(
    .NUM_BP (NUM_BP)
  ) u_en_decode (
    .dr7_lg (dr7[2*NUM_BP-1:0]),
    .en     (en)
  );

  // Raw hits are accumulated; the enable mask only gates the decision.
  assign new_hits  = rd_debug_read | (wr_valid ? wr_debug_write : '0);
  assign acc_hits  = pend_reg | new_hits;
  assign code_hits = exe_debug_exec & en;
  assign trap_go   = instr_done && (((acc_hits & en) != '0) || tf_l_reg);
  assign fault_go  = exe_start && (code_hits != '0) && !eflags_rf;

`ifdef AO486_DEBUG_GD_EN
  logic unused_bits;
  assign gd_go       = mov_dr_access & dr7[DR7_GD];
  assign dr6_bd      = dr6_bd_reg;
  assign gd_clr      = dr6_wr_reg & dr6_bd_reg;
  assign unused_bits = ^{dr7[31:2*NUM_BP], rd_ready};
`else
  logic unused_bits;
  assign gd_go       = 1'b0;
  assign dr6_bd      = 1'b0;
  assign unused_bits = ^{dr7[31:2*NUM_BP], rd_ready, mov_dr_access, dr6_bd_reg};
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      pend_reg   <= '0;
      tf_l_reg   <= 1'b0;
      dr6_wr_reg <= 1'b0;
      dr6_b_reg  <= '0;
      dr6_bs_reg <= 1'b0;
      dr6_bd_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= pend_next;
      tf_l_reg   <= tf_l_next;
      dr6_wr_reg <= dr6_wr_next;
      dr6_b_reg  <= dr6_b_next;
      dr6_bs_reg <= dr6_bs_next;
      dr6_bd_reg <= dr6_bd_next;
    end
  end

  // Next-state logic; priority: flush, trap on retire, GD fault, code fault
  always_comb begin
    state_next  = state_reg;
    pend_next   = pend_reg;
    tf_l_next   = tf_l_reg;
    dr6_wr_next = 1'b0;
    dr6_b_next  = dr6_b_reg;
    dr6_bs_next = dr6_bs_reg;
    dr6_bd_next = dr6_bd_reg;

    if (flush) begin
      state_next = ST_RUN;
      pend_next  = '0;
      tf_l_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          pend_next = acc_hits;
          if (exe_start) tf_l_next = eflags_tf;
          if (trap_go) begin
            state_next  = ST_TRAP_REQ;
            dr6_wr_next = 1'b1;
            dr6_b_next  = acc_hits;
            dr6_bs_next = tf_l_reg;
            dr6_bd_next = 1'b0;
          end else if (gd_go) begin
            state_next  = ST_FAULT_REQ;
            dr6_wr_next = 1'b1;
            dr6_b_next  = '0;
            dr6_bs_next = 1'b0;
            dr6_bd_next = 1'b1;
          end else if (fault_go) begin
            state_next  = ST_FAULT_REQ;
            dr6_wr_next = 1'b1;
            dr6_b_next  = code_hits;
            dr6_bs_next = 1'b0;
            dr6_bd_next = 1'b0;
          end else if (instr_done) begin
            // Retired cleanly: drop its hits; a same-cycle new instruction still latches TF
            pend_next = '0;
            tf_l_next = exe_start ? eflags_tf : 1'b0;
          end
        end
        ST_TRAP_REQ, ST_FAULT_REQ: begin
          if (exc_ack) begin
            state_next = ST_RUN;
            pend_next  = '0;
            tf_l_next  = 1'b0;
          end
        end
        default: begin
          state_next = ST_RUN;
          pend_next  = '0;
          tf_l_next  = 1'b0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    debug_exc_req   = (state_reg != ST_RUN);
    debug_exc_fault = (state_reg == ST_FAULT_REQ);
    busy            = (state_reg != ST_RUN);
    dr6_wr          = dr6_wr_reg;
    dr6_b           = dr6_b_reg;
    dr6_bs          = dr6_bs_reg;
  end

endmodule
